// File: rtl/pipe_hazard_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_if
// Brief    : Control bundle between the pipeline datapath and its hazard sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_hazard_if #(
  parameter int NREGS = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic [15:0]      id_instr;
  logic             id_valid;
  logic             ex_branch_taken;
  logic             wb_we;
  logic [3:0]       wb_rd;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             issue;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [NREGS-1:0] pending;

  // datapath side
  modport master (
    output start, id_instr, id_valid, ex_branch_taken, wb_we, wb_rd,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, issue, halted,
           state, stall_cnt, pending
  );

  // sequencer side
  modport slave (
    input  start, id_instr, id_valid, ex_branch_taken, wb_we, wb_rd,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, issue, halted,
           state, stall_cnt, pending
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_sequencer
// Brief    : Stall/flush/drain control with register scoreboard for the 5-stage
//            pipeline. Define PIPE_FORWARD_EN for load-use-only hazard detection.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_sequencer #(
  parameter int NREGS = 16,
  parameter int CNT_W = 16
) (
  input  logic       clock,
  input  logic       reset,
  pipe_hazard_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [NREGS-1:0] c_reg_one = {{(NREGS-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [NREGS-1:0] r_pending;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_ld_rd_v;
`ifdef PIPE_FORWARD_EN
  logic [3:0]       r_ld_rd;
`endif

  logic [3:0] w_op, w_rd, w_rs1, w_rs2;
  logic       w_real, w_halt_instr, w_jal, w_is_lw;
  logic       w_writer, w_use_rs1, w_use_rs2;
  logic       w_hz1, w_hz2, w_hazard;
  logic       w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_bubble, w_issue;
  state_t     w_state_nx;
  logic [NREGS-1:0] w_set, w_clr;

  assign w_op  = bus.id_instr[3:0];
  assign w_rd  = bus.id_instr[7:4];
  assign w_rs1 = bus.id_instr[11:8];
  assign w_rs2 = bus.id_instr[15:12];

  // 16'h0001 is the bubble encoding the datapath injects
  assign w_real       = bus.id_valid && (bus.id_instr != 16'h0001);
  assign w_halt_instr = bus.id_valid && (bus.id_instr == 16'hFFFF);
  assign w_jal        = w_real && (w_op == 4'd5);
  assign w_is_lw      = w_real && (w_op == 4'd6);

  always_comb begin
    w_writer  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_op)
      4'd0, 4'd5:             w_writer = 1'b1;
      4'd1, 4'd7, 4'd9: begin
        w_writer  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      4'd2, 4'd6: begin
        w_writer  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      4'd3, 4'd4, 4'd8: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PIPE_FORWARD_EN
  assign w_hz1 = w_use_rs1 && (w_rs1 != 4'd0) && r_ld_rd_v && (w_rs1 == r_ld_rd);
  assign w_hz2 = w_use_rs2 && (w_rs2 != 4'd0) && r_ld_rd_v && (w_rs2 == r_ld_rd);
`else
  // registered pending only: a same-cycle write-back lands in the reg file at the edge
  assign w_hz1 = w_use_rs1 && (w_rs1 != 4'd0) && r_pending[w_rs1];
  assign w_hz2 = w_use_rs2 && (w_rs2 != 4'd0) && r_pending[w_rs2];
`endif
  assign w_hazard = w_real && (w_hz1 || w_hz2);

  always_comb begin
    w_pc_en        = 1'b0;
    w_if_id_en     = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b1;
    w_issue        = 1'b0;
    w_state_nx     = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nx = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (bus.ex_branch_taken) begin
          w_pc_en       = 1'b1;
          w_if_id_en    = 1'b1;
          w_if_id_flush = 1'b1;
          w_state_nx    = S_RUN;
        end else if (w_hazard) begin
          w_state_nx = S_STALL;
        end else if (w_halt_instr) begin
          w_state_nx = S_DRAIN;
        end else begin
          w_pc_en        = 1'b1;
          w_if_id_en     = 1'b1;
          w_id_ex_bubble = 1'b0;
          w_issue        = 1'b1;
          w_if_id_flush  = w_jal;
          w_state_nx     = S_RUN;
        end
      end
      S_DRAIN: begin
        if ((r_pending == '0) && !r_ld_rd_v) w_state_nx = S_HALT;
      end
      S_HALT:  w_state_nx = S_HALT;
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_set = (w_issue && w_real && w_writer && (w_rd != 4'd0)) ? (c_reg_one << w_rd) : '0;
  assign w_clr = bus.wb_we ? (c_reg_one << bus.wb_rd) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_stall_cnt <= '0;
      r_ld_rd_v   <= 1'b0;
`ifdef PIPE_FORWARD_EN
      r_ld_rd     <= 4'd0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_pending <= (r_pending & ~w_clr) | w_set;
      if ((r_state == S_STALL) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      r_ld_rd_v <= w_issue && w_is_lw && (w_rd != 4'd0);
`ifdef PIPE_FORWARD_EN
      if (w_issue && w_is_lw) r_ld_rd <= w_rd;
`endif
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.if_id_en     = w_if_id_en;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_bubble = w_id_ex_bubble;
  assign bus.issue        = w_issue;
  assign bus.halted       = (r_state == S_HALT);
  assign bus.state        = r_state;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.pending      = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_sequencer
// Brief    : Directed self-checking bench for pipe_hazard_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_sequencer;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

`ifdef PIPE_FORWARD_EN
  localparam int c_sc2 = 1;
`else
  localparam int c_sc2 = 2;
`endif

  pipe_hazard_if #(.NREGS(16), .CNT_W(16)) bus ();

  pipe_hazard_sequencer #(.NREGS(16), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // apply ID/EX/WB inputs and let the combinational outputs settle
  task automatic drv(input logic [15:0] ins, input logic v, input logic br,
                     input logic we, input logic [3:0] rd);
    bus.id_instr        = ins;
    bus.id_valid        = v;
    bus.ex_branch_taken = br;
    bus.wb_we           = we;
    bus.wb_rd           = rd;
    #2;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.start = 1'b0;
    reset     = 1'b1;
    drv(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("rst_state",   bus.state, 3'd0);
    chk("rst_pending", bus.pending, 16'h0000);
    chk("rst_cnt",     bus.stall_cnt, 16'h0000);
    chk("rst_pc_en",   bus.pc_en, 1'b0);
    chk("rst_bubble",  bus.id_ex_bubble, 1'b1);
    chk("rst_issue",   bus.issue, 1'b0);
    chk("rst_halted",  bus.halted, 1'b0);
    cyc();
    reset = 1'b0;

    // start: enables stay low while still in IDLE
    bus.start = 1'b1;
    #2;
    chk("idle_pc_en", bus.pc_en, 1'b0);
    cyc();
    bus.start = 1'b0;
    chk("run_state", bus.state, 3'd1);

    // 1: ADD r2,r1,r3 ; SUB r4,r5,r6
    drv(16'h3121, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("add_issue",  bus.issue, 1'b1);
    chk("add_pc_en",  bus.pc_en, 1'b1);
    chk("add_bubble", bus.id_ex_bubble, 1'b0);
    chk("add_flush",  bus.if_id_flush, 1'b0);
    cyc();
    chk("add_pending", bus.pending, 16'h0004);
    drv(16'h6549, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("sub_issue", bus.issue, 1'b1);
    cyc();
    chk("sub_pending", bus.pending, 16'h0014);
    chk("t1_cnt",      bus.stall_cnt, 16'd0);
    chk("t1_state",    bus.state, 3'd1);
    drv(16'h0000, 1'b0, 1'b0, 1'b1, 4'd2);
    cyc();
    drv(16'h0000, 1'b0, 1'b0, 1'b1, 4'd4);
    cyc();
    chk("t1_clear", bus.pending, 16'h0000);

    // 2: LW r8 ; ADD r9,r8,r1
    drv(16'h0886, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("lw_issue", bus.issue, 1'b1);
    cyc();
    chk("lw_pending", bus.pending, 16'h0100);
    drv(16'h1891, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("use_issue",  bus.issue, 1'b0);
    chk("use_pc_en",  bus.pc_en, 1'b0);
    chk("use_bubble", bus.id_ex_bubble, 1'b1);
    cyc();
    chk("use_stall", bus.state, 3'd2);
`ifdef PIPE_FORWARD_EN
    drv(16'h1891, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("fwd_issue", bus.issue, 1'b1);
    cyc();
    chk("fwd_state",   bus.state, 3'd1);
    chk("fwd_cnt",     bus.stall_cnt, 16'd1);
    chk("fwd_pending", bus.pending, 16'h0300);
`else
    drv(16'h1891, 1'b1, 1'b0, 1'b1, 4'd8);
    chk("wb_same_cyc_issue", bus.issue, 1'b0);
    cyc();
    chk("wb_state",   bus.state, 3'd2);
    chk("wb_cnt",     bus.stall_cnt, 16'd1);
    chk("wb_pending", bus.pending, 16'h0000);
    drv(16'h1891, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("after_wb_issue", bus.issue, 1'b1);
    cyc();
    chk("after_wb_state",   bus.state, 3'd1);
    chk("after_wb_cnt",     bus.stall_cnt, 16'd2);
    chk("after_wb_pending", bus.pending, 16'h0200);
`endif
    drv(16'h0000, 1'b0, 1'b0, 1'b1, 4'd8);
    cyc();
    drv(16'h0000, 1'b0, 1'b0, 1'b1, 4'd9);
    cyc();
    chk("t2_clear", bus.pending, 16'h0000);

    // 3: taken branch while stalled on load-use
    drv(16'h0886, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc();
    drv(16'h1891, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc();
    chk("t3_stall", bus.state, 3'd2);
    drv(16'h1891, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("br_flush",  bus.if_id_flush, 1'b1);
    chk("br_bubble", bus.id_ex_bubble, 1'b1);
    chk("br_issue",  bus.issue, 1'b0);
    chk("br_pc_en",  bus.pc_en, 1'b1);
    cyc();
    chk("br_state",   bus.state, 3'd1);
    chk("br_pending", bus.pending, 16'h0100);
    chk("br_cnt",     bus.stall_cnt, 16'(c_sc2 + 1));
    drv(16'h0000, 1'b0, 1'b0, 1'b1, 4'd8);
    cyc();

    // 4: JAL r1
    drv(16'h0015, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("jal_issue", bus.issue, 1'b1);
    chk("jal_flush", bus.if_id_flush, 1'b1);
    cyc();
    chk("jal_pending", bus.pending, 16'h0002);
    drv(16'h0000, 1'b0, 1'b0, 1'b1, 4'd1);
    cyc();
    chk("jal_clear", bus.pending, 16'h0000);

    // 5: ADDI r3 ; halt word drains then halts
    drv(16'h0032, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc();
    chk("addi_pending", bus.pending, 16'h0008);
    drv(16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("hlt_pc_en",  bus.pc_en, 1'b0);
    chk("hlt_issue",  bus.issue, 1'b0);
    chk("hlt_bubble", bus.id_ex_bubble, 1'b1);
    cyc();
    chk("drain_state", bus.state, 3'd3);
    drv(16'h0000, 1'b0, 1'b0, 1'b1, 4'd3);
    chk("drain_pc_en", bus.pc_en, 1'b0);
    cyc();
    chk("drain_hold",    bus.state, 3'd3);
    chk("drain_pending", bus.pending, 16'h0000);
    drv(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc();
    chk("halt_state",  bus.state, 3'd4);
    chk("halt_halted", bus.halted, 1'b1);
    bus.start = 1'b1;
    drv(16'h3121, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("halt_pc_en", bus.pc_en, 1'b0);
    chk("halt_issue", bus.issue, 1'b0);
    cyc();
    cyc();
    bus.start = 1'b0;
    chk("halt_sticky", bus.state, 3'd4);

    // 6: asynchronous reset while stalled with pending=0x0104
    reset = 1'b1;
    #1;
    chk("rst2_state", bus.state, 3'd0);
    cyc();
    reset = 1'b0;
    bus.start = 1'b1;
    #2;
    cyc();
    bus.start = 1'b0;
    drv(16'h0022, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc();
    drv(16'h0886, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc();
    drv(16'h1891, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc();
    chk("t6_stall",   bus.state, 3'd2);
    chk("t6_pending", bus.pending, 16'h0104);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state",   bus.state, 3'd0);
    chk("arst_pending", bus.pending, 16'h0000);
    chk("arst_cnt",     bus.stall_cnt, 16'h0000);
    chk("arst_pc_en",   bus.pc_en, 1'b0);
    cyc();
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
